seq_multiplier: RTL and testbench

Parametrised multi-cycle integer multiplier, the successor to the fixed 24-bit mantissa multiplier in the floating-point arithmetic unit. It computes an N×N→2N product with a radix-2 shift-add datapath, one multiplier bit per cycle. Each operation can run in unsigned or two's-complement signed mode. A start/busy/done handshake lets the FPU control FSM issue one multiply and wait for completion. The FP multiply path instantiates it with N=24 for mantissas. Other units use narrower instances.

---
 rtl/seq_multiplier.sv | 91 +++++++++
 tb/tb_seq_multiplier.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add N x N -> 2N multiplier, signed/unsigned, start/busy/done
module seq_multiplier #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] R
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [N-1:0]   m_mag;
  logic [N-1:0]   q_mag;
  logic [2*N-1:0] acc_next;

  // The magnitude of -2^(N-1) is 2^(N-1), which is still representable as N-bit unsigned.
  always_comb begin
    m_mag    = (signed_mode && M[N-1]) ? -M : M;
    q_mag    = (signed_mode && Q[N-1]) ? -Q : Q;
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      R      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, m_mag};
            mplier <= q_mag;
            neg    <= signed_mode & (M[N-1] ^ Q[N-1]);
            acc    <= '0;
            cnt    <= CW'(N);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          // The multiplicand shifts left instead of being aligned by cnt each cycle.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          R     <= neg ? -acc : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier at N=24 and N=8
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start24 = 1'b0, sm24 = 1'b0;
  logic [23:0] m24 = '0, q24 = '0;
  logic        busy24, done24;
  logic [47:0] r24;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] r8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.N(24)) dut24 (
    .clk(clk), .rst(rst), .start(start24), .signed_mode(sm24),
    .M(m24), .Q(q24), .busy(busy24), .done(done24), .R(r24)
  );

  seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .M(m8), .Q(q8), .busy(busy8), .done(done8), .R(r8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as n-bit integers, multiply, wrap to 2n bits.
  function automatic logic [63:0] ref_mul(input int n, input logic [23:0] m,
                                          input logic [23:0] q, input bit s);
    longint a, b, lim;
    lim = longint'(64'd1 << n);
    a = longint'(m) % lim;
    b = longint'(q) % lim;
    if (s && a >= lim / 2) a = a - lim;
    if (s && b >= lim / 2) b = b - lim;
    return 64'(a * b) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  task automatic run_op(input bit w8, input logic [23:0] m, input logic [23:0] q,
                        input bit s, input string tag, output logic [63:0] got);
    int n, lat;
    bit seen, busy_ok;
    logic [63:0] exp;
    n   = w8 ? 8 : 24;
    exp = ref_mul(n, m, q, s);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; m8 = m[7:0]; q8 = q[7:0]; sm8 = s; end
    else    begin start24 = 1'b1; m24 = m; q24 = q; sm24 = s; end
    @(negedge clk);
    start8 = 1'b0; start24 = 1'b0;
    // Scramble inputs: the operation in flight must not notice.
    m8 = 8'($urandom); q8 = 8'($urandom); sm8 = 1'($urandom);
    m24 = 24'($urandom); q24 = 24'($urandom); sm24 = 1'($urandom);
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 60) begin
      if (w8 ? done8 : done24) seen = 1;
      else begin
        if (!(w8 ? busy8 : busy24)) busy_ok = 0;
        @(negedge clk);
        lat++;
      end
    end
    got = w8 ? 64'(r8) : 64'(r24);
    check({tag, "_lat"}, seen ? lat : -1, n + 1);
    check({tag, "_busy_during"}, busy_ok, 1);
    check({tag, "_busy_done"}, w8 ? busy8 : busy24, 0);
    check({tag, "_R"}, got, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, w8 ? done8 : done24, 0);
    check({tag, "_R_hold"}, w8 ? 64'(r8) : 64'(r24), exp);
  endtask

  task automatic handshake;
    logic [23:0] qm[$], qq[$];
    bit          qs[$];
    int          qc[$];
    int          cyc, npush, ndone, pc;
    logic [23:0] mm, qv;
    bit          ss;
    cyc = 0; npush = 0; ndone = 0;
    @(negedge clk);
    start24 = 1'b1;
    while (cyc < 200 && (cyc < 80 || qm.size() > 0)) begin
      if (done24) begin
        if (qm.size() > 0) begin
          mm = qm.pop_front(); qv = qq.pop_front(); ss = qs.pop_front(); pc = qc.pop_front();
          check("hs_R", 64'(r24), ref_mul(24, mm, qv, ss));
          check("hs_lat", cyc - pc - 1, 25);
          ndone++;
        end else check("hs_extra_done", 1, 0);
      end
      if (cyc >= 80) start24 = 1'b0;
      m24 = 24'($urandom); q24 = 24'($urandom); sm24 = 1'($urandom);
      if (start24 && !busy24) begin
        qm.push_back(m24); qq.push_back(q24); qs.push_back(sm24); qc.push_back(cyc);
        npush++;
      end
      @(negedge clk);
      cyc++;
    end
    start24 = 1'b0;
    check("hs_count", ndone, npush);
    check("hs_drained", qm.size(), 0);
  endtask

  logic [63:0] got;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy24", busy24, 0);
    check("rst_done24", done24, 0);
    check("rst_R24", r24, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_R8", r8, 0);
    rst = 1'b0;

    run_op(0, 24'd3000, 24'd71, 0, "u_basic", got);
    check("u_basic_const", got, 64'h000000034008);
    run_op(0, 24'hFFF448, 24'd71, 1, "s_fix", got);
    check("s_fix_const", got, 64'hFFFFFFFCBFF8);
    run_op(0, 24'h800000, 24'h800000, 1, "s_min", got);
    check("s_min_const", got, 64'h400000000000);
    run_op(0, 24'hFFFFFF, 24'hFFFFFF, 0, "u_max", got);
    check("u_max_const", got, 64'hFFFFFE000001);
    run_op(0, 24'h0, 24'hABCDEF, 0, "zero", got);
    check("zero_const", got, 64'h0);

    handshake();

    @(negedge clk);
    start24 = 1'b1; m24 = 24'h123456; q24 = 24'h654321; sm24 = 1'b0;
    @(negedge clk);
    start24 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy24, 0);
    check("abort_done", done24, 0);
    check("abort_R", r24, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 24'd5, 24'd7, 0, "after_rst", got);
    check("after_rst_const", got, 64'd35);

    run_op(1, 24'hFF, 24'hFF, 0, "n8_umax", got);
    check("n8_umax_const", got, 64'hFE01);
    run_op(1, 24'h80, 24'h7F, 1, "n8_smix", got);
    check("n8_smix_const", got, 64'hC080);

    for (int i = 0; i < 16; i++)
      run_op(1, 24'($urandom), 24'($urandom), 1'($urandom), "n8_rand", got);
    for (int i = 0; i < 8; i++)
      run_op(0, 24'($urandom), 24'($urandom), 1'($urandom), "n24_rand", got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
